// File: rtl/win_scan_ctrl.sv
// win_scan_ctrl -- sequencer for the 3x3 window datapath.
//
// Walks the window grid in two-column zigzag strips, requests register-array
// row loads ahead of every window that moves to a new row, and issues BITS
// bit-plane beats (x, y, bit) per window to the window assembler.
//
// Optional build macro: WIN_SCAN_STALL_CNT_EN enables the stall counter
// (cycles with win_vld=1 and win_rdy=0, cleared on start, saturating).
// Without it stall_cnt is tied to zero.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   start                start pulse, honoured only in IDLE
//   pic_size, padding    picture edge length / zero-border enable, latched at start
//   busy, done           scan in progress / one-cycle end-of-scan pulse
//   load_req, load_row   row-load request (held until load_ack) and its top row y
//   load_ack             fetch complete
//   win_vld, win_rdy     beat handshake
//   win_x, win_y         signed top-left window coordinate
//   win_bit, win_last    bit plane (LSB first), final beat of final window
//   stall_cnt            downstream stall cycle count (0 when not built)
module win_scan_ctrl #(
  parameter int BITS = 8,
  parameter int CW   = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [7:0]    pic_size,
  input  logic          padding,
  output logic          busy,
  output logic          done,
  output logic          load_req,
  output logic [CW-1:0] load_row,
  input  logic          load_ack,
  output logic          win_vld,
  input  logic          win_rdy,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  output logic [2:0]    win_bit,
  output logic          win_last,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DONE} state_t;

  localparam logic [2:0]    LAST_BIT = 3'(BITS - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t     state;
  logic       pad_q;
  logic [7:0] w_q;   // window grid edge, 1..255 once a scan is running
  logic [7:0] s_q;   // strip index
  logic [8:0] m_q;   // window index within strip

  // Grid edge from the live inputs, only used at the start edge.
  logic signed [8:0] w_calc;
  logic              w_empty;
  assign w_calc  = $signed({1'b0, pic_size}) - 9'sd2 + (padding ? 9'sd2 : 9'sd0);
  assign w_empty = w_calc[8] || (w_calc == 9'sd0);

  // Strip bookkeeping: an odd grid edge leaves a single-column final strip.
  logic [7:0] s_last_idx;
  logic       last_strip, single, win_end, last_win;
  logic [8:0] nwin;
  logic [8:0] nx0_w;
  assign s_last_idx = (w_q - 8'd1) >> 1;
  assign last_strip = (s_q == s_last_idx);
  assign single     = w_q[0] && last_strip;
  assign nwin       = single ? {1'b0, w_q} : {w_q, 1'b0};
  assign win_end    = (m_q == nwin - 9'd1);
  assign last_win   = last_strip && win_end;
  assign nx0_w      = {s_q + 8'd1, 1'b0} - {8'd0, pad_q};

  // Coordinates of the window after the current one, and whether it
  // starts on a new row (needs a register-array load first).
  logic [CW-1:0] nxt_x, nxt_y;
  logic          nxt_load;
  always_comb begin
    nxt_x    = win_x;
    nxt_y    = win_y;
    nxt_load = 1'b0;
    if (win_end) begin
      nxt_x    = CW'(nx0_w);
      nxt_y    = {CW{pad_q}};
      nxt_load = 1'b1;
    end else if (single) begin
      nxt_y    = win_y + ONE;
      nxt_load = 1'b1;
    end else begin
      case (m_q[1:0])
        2'd0:    nxt_x = win_x + ONE;
        2'd2:    nxt_x = win_x - ONE;
        default: begin
          nxt_y    = win_y + ONE;
          nxt_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      pad_q    <= 1'b0;
      w_q      <= '0;
      s_q      <= '0;
      m_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_req <= 1'b0;
      load_row <= '0;
      win_vld  <= 1'b0;
      win_x    <= '0;
      win_y    <= '0;
      win_bit  <= '0;
      win_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pad_q    <= padding;
          w_q      <= w_calc[7:0];
          s_q      <= '0;
          m_q      <= '0;
          win_bit  <= '0;
          win_last <= 1'b0;
          win_x    <= {CW{padding}};
          win_y    <= {CW{padding}};
          busy     <= 1'b1;
          if (w_empty) begin
            state <= S_DONE;
          end else begin
            load_req <= 1'b1;
            load_row <= {CW{padding}};
            state    <= S_LOAD;
          end
        end
        S_LOAD: if (load_ack) begin
          load_req <= 1'b0;
          win_vld  <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: if (win_rdy) begin
          if (win_bit != LAST_BIT) begin
            win_bit <= win_bit + 3'd1;
            // Flag the final beat one accept early so it is registered.
            if (win_bit == LAST_BIT - 3'd1 && last_win) win_last <= 1'b1;
          end else begin
            win_bit  <= '0;
            win_last <= 1'b0;
            if (last_win) begin
              win_vld <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              win_x <= nxt_x;
              win_y <= nxt_y;
              if (win_end) begin
                s_q <= s_q + 8'd1;
                m_q <= '0;
              end else begin
                m_q <= m_q + 9'd1;
              end
              if (nxt_load) begin
                win_vld  <= 1'b0;
                load_req <= 1'b1;
                load_row <= nxt_y;
                state    <= S_LOAD;
              end
            end
          end
        end
        default: begin
          // Entered with done already high after a scan; an empty scan
          // arrives here with done low and raises it one cycle later.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef WIN_SCAN_STALL_CNT_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                       stall_cnt <= '0;
    else if (state == S_IDLE && start) stall_cnt <= '0;
    else if (win_vld && !win_rdy && stall_cnt != '1)
                                       stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Directed bench for win_scan_ctrl: full scans with and without padding, an
// odd grid, downstream stalls with an ignored mid-scan start, an empty scan
// and a mid-scan reset.
module tb_win_scan_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst, start, padding, load_ack, win_rdy;
  logic [7:0]  pic_size;
  logic        busy, done, load_req, win_vld, win_last;
  logic [7:0]  load_row, win_x, win_y;
  logic [2:0]  win_bit;
  logic [31:0] stall_cnt;

  win_scan_ctrl #(.BITS(8), .CW(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .pic_size(pic_size),
    .padding(padding), .busy(busy), .done(done), .load_req(load_req),
    .load_row(load_row), .load_ack(load_ack), .win_vld(win_vld),
    .win_rdy(win_rdy), .win_x(win_x), .win_y(win_y), .win_bit(win_bit),
    .win_last(win_last), .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_scan.
  int         n_win, n_beat, n_load, bit_err, hold_err, row_err, last_cnt;
  bit         done_seen, timeout;
  logic       busy1, lreq1;
  logic [7:0] first_row;
  logic [7:0] wx[$];
  logic [7:0] wy[$];

  // Drives one scan: start, 5-cycle load_ack latency, optional 20-cycle
  // stall at bit 3 of every window, optional ignored start/config change.
  // Stops on done, or before accepting beat 4 of window abort_win.
  task automatic run_scan(input logic [7:0] ps, input logic pd, input bit stall_en,
                          input int abort_win, input bit pulse_mid);
    int ack_wait, stall_left, exp_bit, cyc;
    logic [7:0] sx, sy, last_row;
    logic [2:0] sb;
    logic       sl;
    bit         load_since;
    n_win = 0; n_beat = 0; n_load = 0; bit_err = 0; hold_err = 0; row_err = 0;
    last_cnt = 0; done_seen = 0; timeout = 0;
    wx.delete(); wy.delete();
    sx = '0; sy = '0; sb = '0; sl = 1'b0;
    pic_size = ps; padding = pd; win_rdy = 1'b1; load_ack = 1'b0;
    @(negedge sys_clk) start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    busy1 = busy; lreq1 = load_req; first_row = load_row;
    if (pulse_mid) begin pic_size = 8'd3; padding = ~pd; end
    ack_wait = 0; stall_left = 20; exp_bit = 0; last_row = load_row; load_since = 1'b0;
    for (cyc = 0; cyc < 40000; cyc++) begin
      if (done) begin done_seen = 1'b1; break; end
      load_ack = 1'b0;
      start = 1'b0;
      win_rdy = 1'b1;
      if (load_req) begin
        if (ack_wait == 5) begin
          load_ack = 1'b1; n_load++; last_row = load_row; load_since = 1'b1; ack_wait = 0;
        end else ack_wait++;
      end
      if (win_vld) begin
        if (abort_win >= 0 && n_win == abort_win + 1 && win_bit == 3'd4) break;
        if (stall_en && win_bit == 3'd3 && stall_left > 0) begin
          win_rdy = 1'b0;
          if (stall_left == 20) begin
            sx = win_x; sy = win_y; sb = win_bit; sl = win_last;
          end else if (win_x !== sx || win_y !== sy || win_bit !== sb || win_last !== sl)
            hold_err++;
          if (pulse_mid && n_win == 3 && stall_left == 10) start = 1'b1;
          stall_left--;
        end else begin
          if (win_bit !== 3'(exp_bit)) bit_err++;
          if (win_bit == 3'd0) begin
            wx.push_back(win_x); wy.push_back(win_y); n_win++;
            if (load_since && win_y !== last_row) row_err++;
            load_since = 1'b0;
          end
          if (win_last) begin
            last_cnt++;
            if (win_bit !== 3'd7) bit_err++;
          end
          if (win_bit == 3'd7) stall_left = 20;
          n_beat++;
          exp_bit = (exp_bit + 1) % 8;
        end
      end
      @(posedge sys_clk); #1;
    end
    if (cyc >= 40000) timeout = 1'b1;
    start = 1'b0; load_ack = 1'b0; win_rdy = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; pic_size = 8'd8; padding = 1'b0;
    load_ack = 1'b0; win_rdy = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (load_req !== 1'b0) begin errors++; $display("FAIL rst_load_req got %b exp 0", load_req); end
    checks++; if (win_vld !== 1'b0) begin errors++; $display("FAIL rst_win_vld got %b exp 0", win_vld); end
    checks++; if ({win_last, win_bit, win_x, win_y, load_row} !== 28'd0)
      begin errors++; $display("FAIL rst_coords got %h exp 0", {win_last, win_bit, win_x, win_y, load_row}); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    @(negedge sys_clk) sys_rst = 1'b0;
  endtask

  task automatic test_scan_pad1();
    run_scan(8'd8, 1'b1, 1'b0, -1, 1'b0);
    checks++; if (busy1 !== 1'b1 || lreq1 !== 1'b1) begin errors++; $display("FAIL p1_start busy/req got %b%b exp 11", busy1, lreq1); end
    checks++; if (first_row !== 8'hFF) begin errors++; $display("FAIL p1_first_row got %h exp ff", first_row); end
    checks++; if (done_seen !== 1'b1 || timeout) begin errors++; $display("FAIL p1_done got %b exp 1", done_seen); end
    checks++; if (n_win !== 64) begin errors++; $display("FAIL p1_nwin got %0d exp 64", n_win); end
    checks++; if (n_beat !== 512) begin errors++; $display("FAIL p1_nbeat got %0d exp 512", n_beat); end
    checks++; if (n_load !== 32) begin errors++; $display("FAIL p1_nload got %0d exp 32", n_load); end
    checks++; if ({wx[0], wy[0], wx[1], wy[1]} !== {8'hFF, 8'hFF, 8'h00, 8'hFF})
      begin errors++; $display("FAIL p1_win01 got %h exp ffff00ff", {wx[0], wy[0], wx[1], wy[1]}); end
    checks++; if ({wx[2], wy[2], wx[3], wy[3]} !== {8'h00, 8'h00, 8'hFF, 8'h00})
      begin errors++; $display("FAIL p1_win23 got %h exp 0000ff00", {wx[2], wy[2], wx[3], wy[3]}); end
    checks++; if ({wx[63], wy[63]} !== {8'd5, 8'd6}) begin errors++; $display("FAIL p1_last_win got %h exp 0506", {wx[63], wy[63]}); end
    checks++; if (last_cnt !== 1) begin errors++; $display("FAIL p1_win_last_cnt got %0d exp 1", last_cnt); end
    checks++; if (bit_err !== 0) begin errors++; $display("FAIL p1_bit_seq got %0d exp 0", bit_err); end
    checks++; if (row_err !== 0) begin errors++; $display("FAIL p1_load_row got %0d exp 0", row_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p1_busy_at_done got %b exp 0", busy); end
    @(posedge sys_clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL p1_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_scan_pad0();
    run_scan(8'd8, 1'b0, 1'b0, -1, 1'b0);
    checks++; if (n_win !== 36) begin errors++; $display("FAIL p0_nwin got %0d exp 36", n_win); end
    checks++; if (n_beat !== 288) begin errors++; $display("FAIL p0_nbeat got %0d exp 288", n_beat); end
    checks++; if (n_load !== 18) begin errors++; $display("FAIL p0_nload got %0d exp 18", n_load); end
    checks++; if ({wx[0], wy[0]} !== 16'h0000) begin errors++; $display("FAIL p0_first got %h exp 0000", {wx[0], wy[0]}); end
    checks++; if ({wx[35], wy[35]} !== {8'd4, 8'd5}) begin errors++; $display("FAIL p0_last got %h exp 0405", {wx[35], wy[35]}); end
    checks++; if (row_err !== 0 || bit_err !== 0) begin errors++; $display("FAIL p0_seq got %0d/%0d exp 0/0", row_err, bit_err); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_odd_grid();
    run_scan(8'd7, 1'b0, 1'b0, -1, 1'b0);
    checks++; if (n_win !== 25) begin errors++; $display("FAIL odd_nwin got %0d exp 25", n_win); end
    checks++; if (n_load !== 15) begin errors++; $display("FAIL odd_nload got %0d exp 15", n_load); end
    checks++; if ({wx[20], wy[20], wx[22], wy[22]} !== {8'd4, 8'd0, 8'd4, 8'd2})
      begin errors++; $display("FAIL odd_strip got %h exp 04000402", {wx[20], wy[20], wx[22], wy[22]}); end
    checks++; if ({wx[24], wy[24]} !== {8'd4, 8'd4}) begin errors++; $display("FAIL odd_last got %h exp 0404", {wx[24], wy[24]}); end
    checks++; if (last_cnt !== 1 || row_err !== 0) begin errors++; $display("FAIL odd_last_flag got %0d/%0d exp 1/0", last_cnt, row_err); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_stall();
    run_scan(8'd4, 1'b0, 1'b1, -1, 1'b1);
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL st_hold got %0d exp 0", hold_err); end
    checks++; if (n_win !== 4 || n_beat !== 32) begin errors++; $display("FAIL st_counts got %0d/%0d exp 4/32", n_win, n_beat); end
    checks++; if (n_load !== 2) begin errors++; $display("FAIL st_nload got %0d exp 2", n_load); end
    checks++; if ({wx[2], wy[2], wx[3], wy[3]} !== {8'd1, 8'd1, 8'd0, 8'd1})
      begin errors++; $display("FAIL st_wins got %h exp 01010001", {wx[2], wy[2], wx[3], wy[3]}); end
`ifdef WIN_SCAN_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd80) begin errors++; $display("FAIL st_stall_cnt got %0d exp 80", stall_cnt); end
`else
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL st_stall_cnt got %0d exp 0", stall_cnt); end
`endif
    @(posedge sys_clk); #1;
  endtask

  task automatic test_empty();
    pic_size = 8'd2; padding = 1'b0;
    @(negedge sys_clk) start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    checks++; if ({busy, done, load_req, win_vld} !== 4'b1000) begin errors++; $display("FAIL em_n0 got %b exp 1000", {busy, done, load_req, win_vld}); end
    @(posedge sys_clk); #1;
    checks++; if ({busy, done, load_req, win_vld} !== 4'b0100) begin errors++; $display("FAIL em_n1 got %b exp 0100", {busy, done, load_req, win_vld}); end
    @(posedge sys_clk); #1;
    checks++; if ({busy, done, load_req, win_vld} !== 4'b0000) begin errors++; $display("FAIL em_n2 got %b exp 0000", {busy, done, load_req, win_vld}); end
  endtask

  task automatic test_reset_mid();
    run_scan(8'd8, 1'b1, 1'b0, 10, 1'b0);
    checks++; if (n_win !== 11 || win_bit !== 3'd4) begin errors++; $display("FAIL rm_reach got %0d/%0d exp 11/4", n_win, win_bit); end
    sys_rst = 1'b1;
    #2;
    checks++; if ({busy, done, load_req, win_vld, win_last} !== 5'b0)
      begin errors++; $display("FAIL rm_ctrl got %b exp 00000", {busy, done, load_req, win_vld, win_last}); end
    checks++; if ({win_bit, win_x, win_y, load_row} !== 27'd0)
      begin errors++; $display("FAIL rm_coords got %h exp 0", {win_bit, win_x, win_y, load_row}); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rm_no_done got %b exp 0", done_seen); end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst = 1'b0;
    run_scan(8'd8, 1'b1, 1'b0, -1, 1'b0);
    checks++; if (first_row !== 8'hFF) begin errors++; $display("FAIL rm_first_row got %h exp ff", first_row); end
    checks++; if ({wx[0], wy[0]} !== 16'hFFFF) begin errors++; $display("FAIL rm_first_win got %h exp ffff", {wx[0], wy[0]}); end
    checks++; if (n_win !== 64 || bit_err !== 0) begin errors++; $display("FAIL rm_rescan got %0d/%0d exp 64/0", n_win, bit_err); end
    @(posedge sys_clk); #1;
  endtask

  initial begin
    test_reset();
    test_scan_pad1();
    test_scan_pad0();
    test_odd_grid();
    test_stall();
    test_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
